shift_counter_gen: RTL and testbench

- Parametrised Johnson/ring shift counter; generation-two replacement for the fixed 8-bit Johnson counter.
- Adds selectable mode (twisted-ring Johnson or one-hot ring), count enable, direction control and parallel load.
- Adds illegal-state self-correction, a decoded phase index and a wrap (terminal-count) pulse.
- Used as a sequencer, phase generator or clock-enable source in the digital-design block library.

---
 rtl/shift_counter_gen.sv | 116 +++++++++++
 tb/tb_shift_counter_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_counter_gen.sv
// Parametrised Johnson / one-hot ring shift counter with enable, direction, parallel load,
// illegal-state self-correction, combinational phase decode and a registered wrap pulse.
module shift_counter_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 0,
    localparam int unsigned N    = (MODE != 0) ? WIDTH : 2 * WIDTH,
    localparam int unsigned PW   = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             tc,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] RST = (MODE != 0) ? WIDTH'(1) : '0;

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] step_fwd, step_rev;
    logic             cur_legal, load_legal;

    // Johnson codes have at most one 0/1 boundary between adjacent bits.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int unsigned edges;
        edges = 0;
        if (MODE != 0) begin
            return $onehot(v);
        end
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        return (edges <= 1);
    endfunction

    function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] v);
        int unsigned idx;
        int unsigned ones;
        idx  = 0;
        ones = 0;
        if (!is_legal(v)) begin
            return '0;
        end
        if (MODE != 0) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (v[i]) idx = i;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (v[i]) ones++;
            end
            // Upper half of the sequence: W + (number of low zeros) = 2W - ones.
            idx = v[WIDTH-1] ? (2 * WIDTH - ones) : ones;
        end
        return PW'(idx);
    endfunction

    always_comb begin
        if (MODE != 0) begin
            step_fwd = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            step_rev = {out_q[0], out_q[WIDTH-1:1]};
        end else begin
            step_fwd = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
            step_rev = {~out_q[0], out_q[WIDTH-1:1]};
        end
    end

    assign cur_legal  = is_legal(out_q);
    assign load_legal = is_legal(load_val);
    assign phase      = phase_of(out_q);

    always_comb begin
        out_d     = out_q;
        tc_d      = 1'b0;
        illegal_d = 1'b0;
        if (load) begin
            if (load_legal) begin
                out_d = load_val;
            end else begin
                out_d     = RST;
                illegal_d = 1'b1;
            end
        end else if (en) begin
            if (cur_legal) begin
                out_d = dir ? step_rev : step_fwd;
                tc_d  = dir ? (phase == '0) : (phase == PW'(N - 1));
            end else begin
                out_d     = RST;
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= RST;
            tc_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            tc_q      <= tc_d;
            illegal_q <= illegal_d;
        end
    end

    assign out     = out_q;
    assign tc      = tc_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Directed bench for shift_counter_gen: W4 Johnson, W4 ring and W8 Johnson instances.
module tb_shift_counter_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Instance A: WIDTH 4, Johnson
    logic       a_reset = 1'b1, a_en = 1'b0, a_dir = 1'b0, a_load = 1'b0;
    logic [3:0] a_lv = '0, a_out;
    logic [2:0] a_phase;
    logic       a_tc, a_ill;

    // Instance B: WIDTH 4, ring
    logic       b_reset = 1'b1, b_en = 1'b0, b_dir = 1'b0, b_load = 1'b0;
    logic [3:0] b_lv = '0, b_out;
    logic [2:0] b_phase;
    logic       b_tc, b_ill;

    // Instance C: WIDTH 8, Johnson
    logic       c_reset = 1'b1, c_en = 1'b0, c_dir = 1'b0, c_load = 1'b0;
    logic [7:0] c_lv = '0, c_out;
    logic [3:0] c_phase;
    logic       c_tc, c_ill;

    logic [3:0] t1_out [0:8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    int unsigned tc_count;

    shift_counter_gen #(.WIDTH(4), .MODE(0)) u_a (
        .clk(clk), .reset(a_reset), .en(a_en), .dir(a_dir), .load(a_load), .load_val(a_lv),
        .out(a_out), .phase(a_phase), .tc(a_tc), .illegal(a_ill)
    );

    shift_counter_gen #(.WIDTH(4), .MODE(1)) u_b (
        .clk(clk), .reset(b_reset), .en(b_en), .dir(b_dir), .load(b_load), .load_val(b_lv),
        .out(b_out), .phase(b_phase), .tc(b_tc), .illegal(b_ill)
    );

    shift_counter_gen #(.WIDTH(8), .MODE(0)) u_c (
        .clk(clk), .reset(c_reset), .en(c_en), .dir(c_dir), .load(c_load), .load_val(c_lv),
        .out(c_out), .phase(c_phase), .tc(c_tc), .illegal(c_ill)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Test 1: W4 Johnson forward full cycle
        tick();
        chk("t1_rst_out", 32'(a_out), 32'h0);
        chk("t1_rst_phase", 32'(a_phase), 32'd0);
        chk("t1_rst_tc", 32'(a_tc), 32'd0);
        chk("t1_rst_ill", 32'(a_ill), 32'd0);
        a_reset = 1'b0;
        a_en    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("t1_out_%0d", i), 32'(a_out), 32'(t1_out[i]));
            chk($sformatf("t1_phase_%0d", i), 32'(a_phase), 32'(i % 8));
            chk($sformatf("t1_tc_%0d", i), 32'(a_tc), 32'(i == 8));
        end

        // Test 2: W4 Johnson reverse from reset, then direction flip
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_dir   = 1'b1;
        tick();
        chk("t2_out_1", 32'(a_out), 32'h8);
        chk("t2_phase_1", 32'(a_phase), 32'd7);
        chk("t2_tc_1", 32'(a_tc), 32'd1);
        tick();
        chk("t2_out_2", 32'(a_out), 32'hC);
        chk("t2_tc_2", 32'(a_tc), 32'd0);
        tick();
        chk("t2_out_3", 32'(a_out), 32'hE);
        chk("t2_phase_3", 32'(a_phase), 32'd5);
        a_dir = 1'b0;
        tick();
        chk("t2_out_flip", 32'(a_out), 32'hC);
        chk("t2_phase_flip", 32'(a_phase), 32'd6);
        chk("t2_tc_flip", 32'(a_tc), 32'd0);

        // Test 3: W4 ring with enable toggling
        tick();
        chk("t3_rst_out", 32'(b_out), 32'h1);
        chk("t3_rst_phase", 32'(b_phase), 32'd0);
        b_reset = 1'b0;
        b_en    = 1'b1;
        tick();
        chk("t3_out_1", 32'(b_out), 32'h2);
        chk("t3_phase_1", 32'(b_phase), 32'd1);
        b_en = 1'b0;
        tick();
        chk("t3_hold_out", 32'(b_out), 32'h2);
        chk("t3_hold_tc", 32'(b_tc), 32'd0);
        b_en = 1'b1;
        tick();
        chk("t3_out_3", 32'(b_out), 32'h4);
        tick();
        chk("t3_out_4", 32'(b_out), 32'h8);
        chk("t3_phase_4", 32'(b_phase), 32'd3);
        chk("t3_tc_4", 32'(b_tc), 32'd0);
        tick();
        chk("t3_wrap_out", 32'(b_out), 32'h1);
        chk("t3_wrap_tc", 32'(b_tc), 32'd1);
        b_dir = 1'b1;
        tick();
        chk("t3_rev_out", 32'(b_out), 32'h8);
        chk("t3_rev_phase", 32'(b_phase), 32'd3);
        chk("t3_rev_tc", 32'(b_tc), 32'd1);
        b_en = 1'b0;

        // Test 4: W4 Johnson loads, illegal and legal
        a_load = 1'b1;
        a_lv   = 4'h5;
        tick();
        chk("t4_ill_out", 32'(a_out), 32'h0);
        chk("t4_ill_flag", 32'(a_ill), 32'd1);
        chk("t4_ill_tc", 32'(a_tc), 32'd0);
        a_lv = 4'h7;
        tick();
        chk("t4_leg_out", 32'(a_out), 32'h7);
        chk("t4_leg_phase", 32'(a_phase), 32'd3);
        chk("t4_leg_flag", 32'(a_ill), 32'd0);
        a_lv = 4'hF;
        tick();
        chk("t4_ones_phase", 32'(a_phase), 32'd4);
        a_load = 1'b0;
        a_en   = 1'b0;
        tick();
        chk("t4_hold_out", 32'(a_out), 32'hF);
        chk("t4_hold_ill", 32'(a_ill), 32'd0);

        // Test 5: W8 Johnson illegal load then a full 16-step cycle
        c_reset = 1'b0;
        c_load  = 1'b1;
        c_lv    = 8'h5A;
        tick();
        chk("t5_corr_out", 32'(c_out), 32'h00);
        chk("t5_corr_flag", 32'(c_ill), 32'd1);
        c_load   = 1'b0;
        c_en     = 1'b1;
        tc_count = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (c_tc) tc_count++;
            if (i == 1) chk("t5_flag_clear", 32'(c_ill), 32'd0);
            if (i == 8) chk("t5_mid_out", 32'(c_out), 32'hFF);
            if (i == 9) chk("t5_mid_phase", 32'(c_phase), 32'd9);
        end
        chk("t5_end_out", 32'(c_out), 32'h00);
        chk("t5_end_tc", 32'(c_tc), 32'd1);
        chk("t5_tc_count", tc_count, 32'd1);
        c_en = 1'b0;

        // Test 6: reset overriding load and en mid-sequence
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_en    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_pre_phase", 32'(a_phase), 32'd5);
        a_reset = 1'b1;
        a_load  = 1'b1;
        a_lv    = 4'h3;
        tick();
        chk("t6_rst_out", 32'(a_out), 32'h0);
        chk("t6_rst_phase", 32'(a_phase), 32'd0);
        chk("t6_rst_tc", 32'(a_tc), 32'd0);
        chk("t6_rst_ill", 32'(a_ill), 32'd0);
        a_reset = 1'b0;
        a_load  = 1'b0;
        tick();
        chk("t6_resume_out", 32'(a_out), 32'h1);
        chk("t6_resume_phase", 32'(a_phase), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
